ifetch_sram_master: RTL and testbench

Instruction-fetch front end that sits directly upstream of the instruction cache. Generates the sequential PC stream, drives the cache's sram-like read port (inst_req / inst_addr_ok / inst_data_ok), and tracks the single outstanding request. Handles branch/exception redirects by flushing and discarding stale responses. Buffers returned instructions with their PCs in a small FIFO that feeds the decode stage through a valid/ready handshake.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_fifo.sv | 47 ++++
 rtl/ifetch_sram_master.sv | 128 ++++++++++++
 tb/tb_ifetch_sram_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
  localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction FIFO between the fetch control and decode.
// Registered storage; the head is read straight from the array.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  fetch_entry_t mem_q [DEPTH];

  // Flush wins over push and pop issued in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ifetch_sram_master.sv
// Fetch front end: sequential PC generation, sram-like icache request port with one
// outstanding request, redirect flush with stale-response discard, and the decode FIFO.
module ifetch_sram_master
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel,
  input  logic        out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          started_q;
  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;
  logic          halted_q, halted_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_data;
  logic          push, pop;
  logic          credit, misaligned, addr_hs, data_push, adel_push;

  // Room for every entry that could still land: queued plus in flight.
  assign credit = ({1'b0, fifo_count} + {{CW{1'b0}}, outstanding_q}) < (CW+1)'(DEPTH);

  always_comb begin
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    halted_d      = halted_q;

    misaligned = (pc_q[1:0] != 2'b00);
    inst_req   = started_q & ~halted_q & ~redirect_valid & ~misaligned & credit
               & (~outstanding_q | inst_data_ok);
    addr_hs    = inst_req & inst_addr_ok;
    data_push  = inst_data_ok & ~discard_q & ~redirect_valid;
    adel_push  = started_q & ~halted_q & ~outstanding_q & credit & ~redirect_valid & misaligned;
    push       = data_push | adel_push;
    pop        = out_valid & out_ready & ~redirect_valid;

    if (adel_push) begin
      push_data = '{pc: pc_q, inst: 32'h0, adel: 1'b1};
    end else begin
      push_data = '{pc: pend_pc_q, inst: inst_rdata, adel: 1'b0};
    end

    if (inst_data_ok) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (addr_hs) begin
      outstanding_d = 1'b1;
      pend_pc_d     = pc_q;
      pc_d          = pc_q + 32'd4;
    end
    if (adel_push) begin
      halted_d = 1'b1;
    end
    // A response still in flight at redirect time belongs to the old stream.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      if (outstanding_q & ~inst_data_ok) begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q          <= RESET_PC;
      pend_pc_q     <= '0;
      started_q     <= 1'b0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      started_q     <= 1'b1;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign inst_wr    = 1'b0;
  assign inst_size  = INST_SIZE_WORD;
  assign inst_addr  = pc_q;
  assign inst_wdata = 32'h0;
  assign out_valid  = (fifo_count != '0);
  assign out_pc     = fifo_head.pc;
  assign out_inst   = fifo_head.inst;
  assign out_adel   = fifo_head.adel;

endmodule

// File: tb/tb_ifetch_sram_master.sv
// Self-checking bench: randomised icache slave, expected-stream scoreboard per fetch epoch.
`timescale 1ns/1ps
module tb_ifetch_sram_master;
  import ifetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam int unsigned DEPTH  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [31:0] inst_rdata = '0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_adel;
  logic [31:0] out_pc, out_inst;
  logic        out_ready = 1'b0;

  ifetch_sram_master #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_adel(out_adel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0, n_pops = 0, n_accept = 0;
  fetch_entry_t exp_q[$];
  logic [31:0] exp_tail = '0;
  bit          exp_halt = 1'b0;
  int unsigned epoch = 0;

  bit          sl_pend = 1'b0;
  logic [31:0] sl_addr = '0;
  int unsigned sl_epoch = 0, sl_cnt = 0;
  int unsigned aok_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit          redir_pend = 1'b0;
  int unsigned redir_mode = 0;
  logic [31:0] redir_target = '0;

  // Instruction memory contents as seen by the slave and the model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3c5a96e1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic topup();
    while (!exp_halt && exp_q.size() < 16) begin
      exp_q.push_back('{pc: exp_tail, inst: mem_word(exp_tail), adel: 1'b0});
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  // New fetch stream: sequential words from pc, or a single address-error marker.
  task automatic start_epoch(input logic [31:0] pc);
    exp_q.delete();
    epoch++;
    if (pc[1:0] != 2'b00) begin
      exp_q.push_back('{pc: pc, inst: 32'h0, adel: 1'b1});
      exp_halt = 1'b1;
    end else begin
      exp_halt = 1'b0;
      exp_tail = pc;
    end
    topup();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    sl_pend = 1'b0; redir_pend = 1'b0;
    start_epoch(RST_PC);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    n_accept = 0;
  endtask

  // One cycle of stimulus: slave response, handshake inputs, optional redirect.
  task automatic step();
    bit fire;
    fire = 1'b0;
    @(negedge clk);
    if (sl_pend && sl_cnt == 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = (sl_epoch == epoch) ? mem_word(sl_addr) : 32'hdeadbeef;
      sl_pend      = 1'b0;
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      if (sl_pend) sl_cnt--;
    end
    inst_addr_ok   = ($urandom_range(99, 0) < aok_pct);
    out_ready      = ($urandom_range(99, 0) < rdy_pct);
    redirect_valid = 1'b0;
    if (redir_pend) begin
      case (redir_mode)
        0:       fire = 1'b1;
        1:       fire = inst_data_ok;
        default: fire = sl_pend;
      endcase
      if (fire) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_target;
        start_epoch(redir_target);
        redir_pend     = 1'b0;
      end
    end
    #1;
    if (resetn && inst_req && inst_addr_ok) begin
      sl_pend  = 1'b1;
      sl_addr  = inst_addr;
      sl_epoch = epoch;
      sl_cnt   = $urandom_range(lat_max, lat_min) - 1;
      n_accept++;
    end
    topup();
  endtask

  task automatic redirect_to(input logic [31:0] tgt, input int unsigned mode);
    redir_target = tgt;
    redir_mode   = mode;
    redir_pend   = 1'b1;
    for (int i = 0; i < 40 && redir_pend; i++) step();
    chk("redirect_issued", 32'(redir_pend), 32'd0);
  endtask

  // Monitor: compares every consumed head entry against the scoreboard.
  bit prev_redir = 1'b0, prev_hold = 1'b0;
  always @(negedge clk) begin
    fetch_entry_t e;
    #2;
    if (resetn === 1'b1) begin
      if (prev_redir) chk("empty_after_redirect", 32'(out_valid), 32'd0);
      if (prev_hold && !redirect_valid) chk("req_held", 32'(inst_req), 32'd1);
      if (out_valid && out_ready && !redirect_valid) begin
        n_pops++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got pc %h, expected no entry", out_pc);
        end else begin
          n_tests--;
          e = exp_q.pop_front();
          chk("pop_pc", out_pc, e.pc);
          chk("pop_inst", out_inst, e.inst);
          chk("pop_adel", 32'(out_adel), 32'(e.adel));
        end
      end
      prev_redir = redirect_valid;
      prev_hold  = inst_req && !inst_addr_ok;
    end else begin
      prev_redir = 1'b0;
      prev_hold  = 1'b0;
    end
  end

  initial begin
    int p0;
    #2 resetn = 1'b0;
    start_epoch(RST_PC);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_addr", inst_addr, RST_PC);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_adel", 32'(out_adel), 32'd0);
    chk("rst_wr", 32'(inst_wr), 32'd0);
    chk("rst_size", 32'(inst_size), 32'd2);
    chk("rst_wdata", inst_wdata, 32'd0);

    // Always-hit slave, decode always ready.
    aok_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    #1 chk("no_req_before_start", 32'(inst_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) begin
        chk("seq_req", 32'(inst_req), 32'd1);
        chk("seq_addr", inst_addr, RST_PC + 32'(4 * k));
      end
      if (k >= 2) begin
        chk("seq_out_valid", 32'(out_valid), 32'd1);
        chk("seq_out_pc", out_pc, RST_PC + 32'(4 * (k - 2)));
      end
    end
    repeat (10) step();

    // Decode stalled: exactly DEPTH fetches, then resume after one pop.
    do_reset();
    rdy_pct = 0;
    repeat (12) step();
    chk("fill_accepts", 32'(n_accept), 32'(DEPTH));
    chk("fill_out_valid", 32'(out_valid), 32'd1);
    chk("fill_no_req", 32'(inst_req), 32'd0);
    rdy_pct = 100; step();
    rdy_pct = 0;   step();
    chk("req_after_pop", 32'(inst_req), 32'd1);
    rdy_pct = 100;
    repeat (12) step();

    // Redirect while a slow response is outstanding.
    lat_min = 4; lat_max = 4;
    redirect_to(32'h80001000, 2);
    step();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    p0 = n_pops;
    repeat (25) step();
    chk("resume_after_discard", 32'(n_pops > p0), 32'd1);

    // Redirect coinciding with the response.
    lat_min = 2; lat_max = 2;
    redirect_to(32'h80002000, 1);
    p0 = n_pops;
    repeat (20) step();
    chk("resume_after_same_cycle", 32'(n_pops > p0), 32'd1);

    // Misaligned target: one address-error entry, then stall.
    lat_min = 1; lat_max = 1;
    redirect_to(32'h80000002, 0);
    p0 = n_pops;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("halt_no_req", 32'(inst_req), 32'd0);
    end
    chk("adel_single_entry", 32'(n_pops - p0), 32'd1);
    redirect_to(32'h80000000, 0);
    p0 = n_pops;
    repeat (10) step();
    chk("resume_after_halt", 32'(n_pops > p0), 32'd1);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    rdy_pct = 0;
    repeat (5) step();
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_req", 32'(inst_req), 32'd0);
    chk("async_addr", inst_addr, RST_PC);
    rdy_pct = 100;
    do_reset();
    step();
    chk("restart_req", 32'(inst_req), 32'd1);
    chk("restart_addr", inst_addr, RST_PC);

    // Randomised traffic with random redirects, misaligned targets and PC wrap.
    aok_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 3;
    p0 = n_pops;
    for (int n = 0; n < 3000; n++) begin
      if (!redir_pend && $urandom_range(99, 0) < 3) begin
        case ($urandom_range(9, 0))
          0:       redir_target = 32'h80000000 | (32'($urandom_range(4095, 0)) << 2) | 32'h2;
          1:       redir_target = 32'hfffffff8;
          default: redir_target = 32'h80000000 | (32'($urandom_range(4095, 0)) << 2);
        endcase
        redir_mode = exp_halt ? 0 : $urandom_range(2, 0);
        redir_pend = 1'b1;
      end
      step();
    end
    chk("random_progress", 32'((n_pops - p0) > 300), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
